// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: controller state encoding and the
// width of the time-multiplexed subtractor slice.
package arith_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_4bit.sv
// 4-bit ripple-borrow subtractor slice: diff = A - B - bin, bout = borrow out.
module subtractor_4bit (
  output logic [3:0] diff,
  output logic       bout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       bin
);

  logic [4:0] brw;

  always_comb begin
    brw    = '0;
    diff   = '0;
    brw[0] = bin;
    for (int i = 0; i < 4; i++) begin
      diff[i]  = A[i] ^ B[i] ^ brw[i];
      brw[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw[i]);
    end
  end

  assign bout = brw[4];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Nibble-serial subtract controller: computes a - b - bin one nibble per clock
// through a single shared 4-bit slice, LSB nibble first.
//
// state   | meaning
// ST_IDLE | in_ready high, waiting for operands
// ST_RUN  | stepping nibble idx through the slice, borrow carried in borrow_q
// ST_DONE | result held on diff/bout/zero until the consumer takes it
module nibble_serial_sub_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_sub_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [NIB_W-1:0]  a_nib, b_nib, slice_diff;
  logic              slice_bout;

  assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
  assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

  subtractor_4bit u_slice (
    .diff (slice_diff),
    .bout (slice_bout),
    .A    (a_nib),
    .B    (b_nib),
    .bin  (borrow_q)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q && !abort) begin
          a_d        = a;
          b_d        = b;
          borrow_d   = bin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[idx_q*NIB_W +: NIB_W] = slice_diff;
        borrow_d = slice_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // zero flag must include the nibble landing on this same edge
          bout_d      = slice_bout;
          zero_d      = (diff_d == '0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort overrides everything, including a same-cycle out_ready in DONE
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      diff_d      = '0;
      bout_d      = 1'b0;
      zero_d      = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed bench for the nibble-serial subtract controller at WIDTH=16.
module tb_nibble_serial_sub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        zero;

  int checks = 0;
  int errors = 0;
  int lat;

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents operands at a negedge, then waits (bounded) for out_valid.
  task automatic start_and_wait(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; bin = 1'b0;
    chk("in_ready_low_in_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    // abort beats in_valid in IDLE
    in_valid = 1'b1; abort = 1'b1; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_in_ready", in_ready, 1);

    start_and_wait(16'h1234, 16'h0234, 1'b0);
    chk("op1_diff", diff, 32'h1000);
    chk("op1_bout", bout, 0);
    chk("op1_zero", zero, 0);
    release_result();

    start_and_wait(16'h0000, 16'h0001, 1'b0);
    chk("op2_diff", diff, 32'hFFFF);
    chk("op2_bout", bout, 1);
    chk("op2_zero", zero, 0);
    release_result();

    start_and_wait(16'h0010, 16'h000F, 1'b1);
    chk("op3_diff", diff, 32'h0000);
    chk("op3_bout", bout, 0);
    chk("op3_zero", zero, 1);
    release_result();

    start_and_wait(16'h5A5A, 16'h5A5A, 1'b1);
    chk("op4_diff", diff, 32'hFFFF);
    chk("op4_bout", bout, 1);
    chk("op4_zero", zero, 0);
    release_result();

    // backpressure: result holds and new operands are ignored
    start_and_wait(16'h8000, 16'h0001, 1'b0);
    in_valid = 1'b1; a = 16'h1111; b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_diff", diff, 32'h7FFF);
      chk("bp_bout", bout, 0);
      chk("bp_zero", zero, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_result();

    // abort at idx==2
    a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);

    start_and_wait(16'h0005, 16'h0003, 1'b0);
    chk("post_abort_diff", diff, 32'h0002);
    chk("post_abort_bout", bout, 0);
    release_result();

    // asynchronous reset mid-RUN
    a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_diff", diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_in_ready", in_ready, 1);

    start_and_wait(16'hFFFF, 16'h0001, 1'b0);
    chk("op_final_diff", diff, 32'hFFFE);
    chk("op_final_bout", bout, 0);
    chk("op_final_zero", zero, 0);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
Sequencing controller that computes a WIDTH-bit difference A - B - bin by time-multiplexing one 4-bit ripple-borrow subtractor slice, one nibble per clock, LSB nibble first.
- Borrow is carried between nibbles in a register.
- Valid/ready handshakes on input and output let it sit between an operand source and a result consumer in the arithmetic datapath.
- Trades area (one slice) for latency (WIDTH/4 cycles).

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIB, WIDTH/4, derived localparam: number of nibble steps

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
in_valid  input  1  operands a, b, bin valid
in_ready  output  1  controller idle and able to accept operands
a  input  WIDTH  minuend (unsigned)
b  input  WIDTH  subtrahend (unsigned)
bin  input  1  borrow-in into nibble 0
abort  input  1  synchronous cancel of the current operation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin modulo 2^WIDTH
bout  output  1  final borrow out of the top nibble (1 means a < b + bin)
zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=0, out_valid=0, diff=0, bout=0, zero=0, idx=0, borrow reg=0, operand regs=0. All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 from the first rising edge after rst_n deasserts.
  - On in_valid && in_ready: capture a, b into operand regs; borrow reg<=bin; idx<=0; in_ready<=0; state<=RUN.
- RUN:
  - The slice sees a_reg[4*idx+:4], b_reg[4*idx+:4] and the borrow reg.
  - Each edge: diff[4*idx+:4]<=slice diff; borrow reg<=slice bout; idx<=idx+1.
  - On the edge where idx==NIB-1: bout<=slice bout; zero<=(completed diff==0, including the nibble written this edge); out_valid<=1; state<=DONE.
  - Diff nibbles not yet written keep their previous values; diff is observable only while out_valid=1.
- DONE:
  - out_valid, diff, bout and zero hold stable until out_valid && out_ready.
  - On that edge: out_valid<=0; in_ready<=1; state<=IDLE.
- Latency: operands accepted at edge E0; out_valid rises at edge E(NIB). For WIDTH=16, that is 4 cycles. For WIDTH=4, it is 1 cycle.
- Throughput: one result per NIB+2 cycles at best. There is no back-to-back acceptance; in_valid is ignored outside IDLE.
- Operand regs hold across RUN, so a and b inputs may change after acceptance.
- abort:
  - High in RUN or DONE: next edge returns to IDLE with out_valid=0, diff=0, bout=0, zero=0, in_ready=1.
  - High in IDLE: no effect; abort wins over in_valid.
  - abort and out_ready together in DONE: abort wins, result discarded.
- out_ready is don't-care outside DONE.
- rst_n low mid-RUN or mid-DONE: immediate return to reset values; partial result lost.
- Arithmetic is unsigned modulo 2^WIDTH. bin=1 with a==b gives diff=all ones, bout=1.

Decomposition:
- Shared package arith_pkg holds the state enum typedef (IDLE/RUN/DONE) and the nibble width constant (4).
- One sub-module, instantiated once: subtractor_4bit, the team's existing 4-bit ripple-borrow slice. Port order: diff, bout, A, B, bin.
- The controller contains the FSM, nibble counter, borrow register, operand registers and result register.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> after 4 cycles out_valid=1, diff=0x1000, bout=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0. The borrow ripples through all 4 nibble steps.
- a=0x0010, b=0x000F, bin=1 -> diff=0x0000, bout=0, zero=1. This is a cross-nibble borrow. Then a=0x5A5A, b=0x5A5A, bin=1 -> diff=0xFFFF, bout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> diff, bout and zero stable, in_ready=0, new in_valid ignored. out_ready=1 -> next edge out_valid=0, in_ready=1.
- Abort at RUN idx=2 -> next edge IDLE, in_ready=1, out_valid=0, diff=0. A following op 0x0005-0x0003 completes with diff=0x0002.
- Assert rst_n=0 asynchronously mid-RUN -> outputs zero immediately. After release, in_ready=1 on the first edge, and a new op 0xFFFF-0x0001 gives 0xFFFE, bout=0.
